// File: rtl/match_count_display.sv
// match_count_display: counts rising edges of z as two BCD digits and
// multiplexes them onto a two-digit active-low seven-segment display.
module match_count_display #(
    parameter int REFRESH_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       z,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       ovf
);
    logic                 z_d_q, z_d_d;
    logic                 arm_q, arm_d;
    logic [3:0]           ones_q, ones_d;
    logic [3:0]           tens_q, tens_d;
    logic                 ovf_q, ovf_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           an_q, an_d;
    logic                 evt;
    logic                 sel;
    logic [3:0]           dig;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    // arm_q masks the first edge after reset so a z already high at release is not an event
    always_comb begin
        z_d_d     = z;
        arm_d     = 1'b1;
        refresh_d = refresh_q + 1'b1;
        evt       = z & ~z_d_q & arm_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        ovf_d     = ovf_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            ovf_d  = 1'b0;
        end else if (evt) begin
            ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
            if (ones_q == 4'd9) begin
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                ovf_d  = ovf_q | (tens_q == 4'd9);
            end
        end
        sel   = refresh_q[REFRESH_W-1];
        dig   = sel ? tens_q : ones_q;
        seg_d = (sel && tens_q == 4'd0) ? 7'h7F : enc(dig);
        an_d  = (sel && tens_q == 4'd0) ? 4'b1111 : (sel ? 4'b1101 : 4'b1110);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_d_q     <= 1'b0;
            arm_q     <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
            seg_q     <= 7'h7F;
            an_q      <= 4'b1111;
        end else begin
            z_d_q     <= z_d_d;
            arm_q     <= arm_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign ovf = ovf_q;
endmodule
